// File: rtl/cnn_top.sv
// Single-image CNN inference core: 8x8 image -> 3x3 valid conv -> ReLU -> 2x2 max-pool -> sum.
// One output position per cycle; the final sum saturates to OUT_W bits.
module cnn_top #(
  parameter int          DATA_W = 32,
  parameter int          OUT_W  = 32,
  parameter logic [71:0] KERNEL = {9{8'sd1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] input_img [0:63],
  output logic [OUT_W-1:0]  value,
  output logic              done
);

  localparam int ACC_W = 42;
  localparam int SUM_W = 46;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SUM  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  img_q [0:63];
  logic [ACC_W-1:0]   pool_q [0:8];
  logic [ACC_W-1:0]   pool_d [0:8];
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               done_q, done_d;
  logic               load_s;

  logic signed [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0]        relu_s;
  logic [3:0]              pidx_s;
  logic [SUM_W-1:0]        total_s;

  // Convolution at the current (row, col) window, ReLU and target pool slot
  always_comb begin : conv_blk
    logic [5:0]              idx;
    logic signed [7:0]       w;
    logic signed [ACC_W-1:0] wx;
    logic signed [ACC_W-1:0] px;
    acc_s = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        idx   = {3'(row_q + 3'(i)), 3'(col_q + 3'(j))};
        w     = KERNEL[8*(3*i+j) +: 8];
        wx    = ACC_W'(w);
        px    = ACC_W'($signed(img_q[idx]));
        acc_s = acc_s + wx * px;
      end
    end
    relu_s = acc_s[ACC_W-1] ? '0 : acc_s;
    pidx_s = 4'(row_q[2:1]) * 4'd3 + 4'(col_q[2:1]);
  end

  // Sum of the pooled map; pool values are non-negative so zero extension is exact
  always_comb begin
    total_s = '0;
    for (int k = 0; k < 9; k++) begin
      total_s = total_s + SUM_W'(pool_q[k]);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    value_d = value_q;
    done_d  = done_q;
    pool_d  = pool_q;
    load_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          load_s  = 1'b1;
          row_d   = 3'd0;
          col_d   = 3'd0;
          done_d  = 1'b0;
          state_d = S_CONV;
          for (int k = 0; k < 9; k++) begin
            pool_d[k] = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (relu_s > pool_q[pidx_s]) begin
          pool_d[pidx_s] = relu_s;
        end else begin
          pool_d[pidx_s] = pool_q[pidx_s];
        end
        if (col_q == 3'd5) begin
          col_d = 3'd0;
          if (row_q == 3'd5) begin
            row_d   = 3'd0;
            state_d = S_SUM;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      S_SUM: begin
        if (total_s > SUM_W'({OUT_W{1'b1}})) begin
          value_d = {OUT_W{1'b1}};
        end else begin
          value_d = total_s[OUT_W-1:0];
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any image in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      value_q <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        pool_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      value_q <= value_d;
      done_q  <= done_d;
      pool_q  <= pool_d;
      if (load_s) begin
        img_q <= input_img;
      end
    end
  end

  assign value = value_q;
  assign done  = done_q;

endmodule

// File: tb/tb_cnn_top.sv
// Randomized self-checking bench for cnn_top against a behavioural array model.
module tb_cnn_top;

  localparam logic [71:0] KERN = {9{8'sd1}};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] input_img [0:63];
  logic [31:0] value;
  logic        done;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  cnn_top #(.DATA_W(32), .OUT_W(32), .KERNEL(KERN)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .input_img (input_img),
    .value     (value),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // conv -> relu -> 2x2 max-pool -> sum, all in 64-bit arithmetic
  function automatic logic [31:0] model(input logic [31:0] img [0:63]);
    longint pool [0:8];
    longint acc;
    longint sum;
    logic signed [7:0] w;
    for (int k = 0; k < 9; k++) pool[k] = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            w   = KERN[8*(3*i+j) +: 8];
            acc = acc + longint'(w) * longint'($signed(img[8*(r+i)+c+j]));
          end
        end
        if (acc > pool[(r/2)*3 + c/2]) pool[(r/2)*3 + c/2] = acc;
      end
    end
    sum = 0;
    for (int k = 0; k < 9; k++) sum = sum + pool[k];
    if (sum > 64'sh0_FFFF_FFFF) return 32'hFFFF_FFFF;
    return sum[31:0];
  endfunction

  task automatic set_const(input logic [31:0] v);
    for (int k = 0; k < 64; k++) input_img[k] = v;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 64; k++) input_img[k] = 32'(k);
  endtask

  // Start an image, scramble the inputs, wander enable during CONV, expect done on E37
  task automatic run_image(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    enable = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) input_img[k] = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        n = k;
        break;
      end
      if (k < 36) enable = 1'($urandom_range(0, 1));
    end
    enable = 1'b1;
    chk({tag, "_lat"}, 64'(n), 64'd37);
    chk({tag, "_val"}, 64'(value), 64'(exp));
  endtask

  task automatic release_en(input string tag, input logic [31:0] held);
    enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_rel_done"}, 64'(done), 64'd0);
    chk({tag, "_rel_val"}, 64'(value), 64'(held));
  endtask

  initial begin
    logic [31:0] exp;
    rst    = 1'b1;
    enable = 1'b1;
    set_const(32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_val", 64'(value), 64'd0);
    rst = 1'b0;

    chk("model_ones", 64'(model(input_img)), 64'd81);
    run_image("ones", 32'd81);
    release_en("ones", 32'd81);

    set_ramp();
    chk("model_ramp", 64'(model(input_img)), 64'd2916);
    run_image("ramp", 32'd2916);
    release_en("ramp", 32'd2916);

    set_const(32'd0);
    run_image("zeros", 32'd0);
    release_en("zeros", 32'd0);

    set_const(32'hFFFF_FFFF);
    run_image("neg1", 32'd0);
    release_en("neg1", 32'd0);

    set_const(32'h7FFF_FFFF);
    run_image("sat", 32'hFFFF_FFFF);
    release_en("sat", 32'hFFFF_FFFF);

    // reset 10 cycles into CONV
    set_const(32'd5);
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_val", 64'(value), 64'd0);
    rst    = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    set_const(32'd1);
    run_image("restart", 32'd81);

    // hold enable in DONE: no restart, value stable
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_done", 64'(done), 64'd1);
      chk("hold_val", 64'(value), 64'd81);
    end
    release_en("hold", 32'd81);
    set_ramp();
    run_image("reraise", 32'd2916);
    release_en("reraise", 32'd2916);

    for (int t = 0; t < 24; t++) begin
      if (t % 3 == 2) begin
        for (int k = 0; k < 64; k++) input_img[k] = $urandom;
      end else begin
        for (int k = 0; k < 64; k++) input_img[k] = 32'($urandom_range(0, 400)) - 32'd200;
      end
      exp = model(input_img);
      run_image("rand", exp);
      release_en("rand", exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
